// File: rtl/sram_like_pkg.sv
// Shared owner encodings, size codes and request-field layout for the
// SRAM-like instruction/data arbiter.
package sram_like_pkg;

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam int ADDR_BITS = 32;
    localparam int DATA_BITS = 32;
    localparam int STRB_BITS = 4;
    localparam int SIZE_BITS = 2;

    typedef struct packed {
        logic                 wr;
        logic [SIZE_BITS-1:0] size;
        logic [STRB_BITS-1:0] wstrb;
        logic [ADDR_BITS-1:0] addr;
        logic [DATA_BITS-1:0] wdata;
    } req_t;

endpackage

// File: rtl/sram_like_arbiter_owner_fifo.sv
// In-order 1-bit owner tag FIFO; a pop while empty is ignored and flagged.
module owner_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic full,
    output logic empty,
    output logic head,
    output logic pop_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_err = pop && empty;

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like slave port between instruction and data masters:
// data-over-inst priority with grant locking, responses routed by owner FIFO.
module sram_like_arbiter
    import sram_like_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        slv_req,
    output logic        slv_wr,
    output logic [1:0]  slv_size,
    output logic [3:0]  slv_wstrb,
    output logic [31:0] slv_addr,
    output logic [31:0] slv_wdata,
    input  logic        slv_addr_ok,
    input  logic        slv_data_ok,
    input  logic [31:0] slv_rdata,

    output logic        idle,
    output logic        proto_err
);

    logic lock_valid, lock_valid_next;
    logic lock_owner, lock_owner_next;
    logic grant_valid;
    logic grant;
    logic locked_req;
    logic granted_req;
    logic fifo_full, fifo_empty, fifo_head, fifo_pop_err;
    logic push, pop;
    req_t inst_f, data_f, sel_f;

    assign inst_f = '{wr: inst_wr, size: inst_size, wstrb: inst_wstrb,
                      addr: inst_addr, wdata: inst_wdata};
    assign data_f = '{wr: data_wr, size: data_size, wstrb: data_wstrb,
                      addr: data_addr, wdata: data_wdata};

    // A lock only binds while its owner still holds req; otherwise fall
    // through to normal priority so the other master can go this cycle.
    assign locked_req = (lock_owner == OWNER_DATA) ? data_req : inst_req;

    always_comb begin
        grant_valid = 1'b0;
        grant       = OWNER_INST;
        if (lock_valid && locked_req) begin
            grant_valid = 1'b1;
            grant       = lock_owner;
        end else if (data_req) begin
            grant_valid = 1'b1;
            grant       = OWNER_DATA;
        end else if (inst_req) begin
            grant_valid = 1'b1;
            grant       = OWNER_INST;
        end
    end

    assign granted_req = (grant == OWNER_DATA) ? data_req : inst_req;
    assign sel_f       = (grant == OWNER_DATA) ? data_f : inst_f;

    assign slv_req   = grant_valid && granted_req && !fifo_full && resetn;
    assign slv_wr    = sel_f.wr;
    assign slv_size  = sel_f.size;
    assign slv_wstrb = sel_f.wstrb;
    assign slv_addr  = sel_f.addr;
    assign slv_wdata = sel_f.wdata;

    assign inst_addr_ok = slv_addr_ok && slv_req && (grant == OWNER_INST);
    assign data_addr_ok = slv_addr_ok && slv_req && (grant == OWNER_DATA);

    always_comb begin
        lock_valid_next = lock_valid;
        lock_owner_next = lock_owner;
        if (lock_valid && !locked_req) lock_valid_next = 1'b0;
        if (slv_req) begin
            if (slv_addr_ok) begin
                lock_valid_next = 1'b0;
            end else begin
                lock_valid_next = 1'b1;
                lock_owner_next = grant;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock_valid <= 1'b0;
            lock_owner <= OWNER_INST;
            proto_err  <= 1'b0;
        end else begin
            lock_valid <= lock_valid_next;
            lock_owner <= lock_owner_next;
            if (fifo_pop_err) proto_err <= 1'b1;
        end
    end

    assign push = slv_req && slv_addr_ok;
    assign pop  = slv_data_ok && resetn;

    owner_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push    (push),
        .pop     (pop),
        .din     (grant),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head),
        .pop_err (fifo_pop_err)
    );

    assign inst_data_ok = pop && !fifo_empty && (fifo_head == OWNER_INST);
    assign data_data_ok = pop && !fifo_empty && (fifo_head == OWNER_DATA);
    assign inst_rdata   = slv_rdata;
    assign data_rdata   = slv_rdata;

    assign idle = fifo_empty && !lock_valid;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: priority, locking, FIFO full/empty,
// response routing and reset behaviour.
module tb_sram_like_arbiter;
    import sram_like_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        slv_req, slv_wr;
    logic [1:0]  slv_size;
    logic [3:0]  slv_wstrb;
    logic [31:0] slv_addr, slv_wdata;
    logic        slv_addr_ok, slv_data_ok;
    logic [31:0] slv_rdata;
    logic        idle, proto_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sram_like_arbiter #(.MAX_OUTSTANDING(4)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_wstrb   (inst_wstrb),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .slv_req      (slv_req),
        .slv_wr       (slv_wr),
        .slv_size     (slv_size),
        .slv_wstrb    (slv_wstrb),
        .slv_addr     (slv_addr),
        .slv_wdata    (slv_wdata),
        .slv_addr_ok  (slv_addr_ok),
        .slv_data_ok  (slv_data_ok),
        .slv_rdata    (slv_rdata),
        .idle         (idle),
        .proto_err    (proto_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then driven mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        inst_req = 1'b1; inst_wr = 1'b0; inst_size = SIZE_W; inst_wstrb = 4'h0;
        inst_addr = 32'h1c00_0000; inst_wdata = 32'h0;
        data_req = 1'b0; data_wr = 1'b0; data_size = SIZE_W; data_wstrb = 4'h0;
        data_addr = 32'h0000_1000; data_wdata = 32'h0;
        slv_addr_ok = 1'b1; slv_data_ok = 1'b1; slv_rdata = 32'h0;
        #1;
        chk("rst_slv_req", 32'(slv_req), 32'd0);
        chk("rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        chk("rst_inst_data_ok", 32'(inst_data_ok), 32'd0);
        tick();
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_proto_err", 32'(proto_err), 32'd0);
        resetn = 1'b1; inst_req = 1'b0; slv_addr_ok = 1'b0; slv_data_ok = 1'b0;
        tick();

        // Both masters in the same cycle: data wins, inst follows.
        inst_req = 1'b1;
        data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hf; data_wdata = 32'hdead_beef;
        slv_addr_ok = 1'b1;
        #1;
        chk("t1_data_addr_ok", 32'(data_addr_ok), 32'd1);
        chk("t1_inst_addr_ok0", 32'(inst_addr_ok), 32'd0);
        chk("t1_slv_addr_data", slv_addr, 32'h0000_1000);
        chk("t1_slv_wr", 32'(slv_wr), 32'd1);
        chk("t1_slv_wdata", slv_wdata, 32'hdead_beef);
        tick();
        data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0;
        #1;
        chk("t1_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
        chk("t1_slv_addr_inst", slv_addr, 32'h1c00_0000);
        tick();
        inst_req = 1'b0; slv_addr_ok = 1'b0;
        slv_data_ok = 1'b1; slv_rdata = 32'h1111_2222;
        #1;
        chk("t1_rsp0_data_ok", 32'(data_data_ok), 32'd1);
        chk("t1_rsp0_inst_ok", 32'(inst_data_ok), 32'd0);
        chk("t1_rsp0_rdata", data_rdata, 32'h1111_2222);
        tick();
        slv_rdata = 32'h3333_4444;
        #1;
        chk("t1_rsp1_inst_ok", 32'(inst_data_ok), 32'd1);
        chk("t1_rsp1_data_ok", 32'(data_data_ok), 32'd0);
        chk("t1_rsp1_rdata", inst_rdata, 32'h3333_4444);
        tick();
        slv_data_ok = 1'b0;
        #1;
        chk("t1_idle", 32'(idle), 32'd1);

        // Inst held off by slave; data arrives but cannot steal the port.
        inst_req = 1'b1; inst_addr = 32'h1c00_0000;
        #1;
        chk("t2_c0_slv_req", 32'(slv_req), 32'd1);
        chk("t2_c0_addr", slv_addr, 32'h1c00_0000);
        tick();
        data_req = 1'b1; data_addr = 32'h0000_1000;
        #1;
        chk("t2_c1_addr_locked", slv_addr, 32'h1c00_0000);
        chk("t2_c1_data_addr_ok", 32'(data_addr_ok), 32'd0);
        chk("t2_c1_idle", 32'(idle), 32'd0);
        tick();
        #1;
        chk("t2_c2_addr_locked", slv_addr, 32'h1c00_0000);
        tick();
        slv_addr_ok = 1'b1;
        #1;
        chk("t2_c3_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
        chk("t2_c3_data_addr_ok", 32'(data_addr_ok), 32'd0);
        tick();
        inst_req = 1'b0;
        #1;
        chk("t2_c4_data_addr_ok", 32'(data_addr_ok), 32'd1);
        chk("t2_c4_addr", slv_addr, 32'h0000_1000);
        tick();
        data_req = 1'b0; slv_addr_ok = 1'b0; slv_data_ok = 1'b1;
        #1;
        chk("t2_rsp0_inst_ok", 32'(inst_data_ok), 32'd1);
        tick();
        #1;
        chk("t2_rsp1_data_ok", 32'(data_data_ok), 32'd1);
        tick();
        slv_data_ok = 1'b0;

        // Locked inst withdraws (redirect); pending data goes the same cycle.
        inst_req = 1'b1;
        tick();
        inst_req = 1'b0; data_req = 1'b1; slv_addr_ok = 1'b1;
        #1;
        chk("t3_slv_req", 32'(slv_req), 32'd1);
        chk("t3_addr", slv_addr, 32'h0000_1000);
        chk("t3_data_addr_ok", 32'(data_addr_ok), 32'd1);
        tick();
        data_req = 1'b0; slv_addr_ok = 1'b0;
        #1;
        chk("t3_busy", 32'(idle), 32'd0);
        slv_data_ok = 1'b1;
        #1;
        chk("t3_data_ok", 32'(data_data_ok), 32'd1);
        tick();
        slv_data_ok = 1'b0;
        #1;
        chk("t3_idle", 32'(idle), 32'd1);

        // Fill the owner FIFO, then a fifth request waits for a pop.
        inst_req = 1'b1; slv_addr_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            inst_addr = 32'h1c00_0000 + 32'(4 * i);
            #1;
            chk("t4_fill_addr_ok", 32'(inst_addr_ok), 32'd1);
            tick();
        end
        inst_addr = 32'h1c00_0010;
        #1;
        chk("t4_full_slv_req", 32'(slv_req), 32'd0);
        chk("t4_full_addr_ok", 32'(inst_addr_ok), 32'd0);
        slv_data_ok = 1'b1;
        #1;
        chk("t4_pop_inst_ok", 32'(inst_data_ok), 32'd1);
        chk("t4_pop_slv_req", 32'(slv_req), 32'd0);
        tick();
        slv_data_ok = 1'b0;
        #1;
        chk("t4_5th_slv_req", 32'(slv_req), 32'd1);
        chk("t4_5th_addr_ok", 32'(inst_addr_ok), 32'd1);
        chk("t4_5th_addr", slv_addr, 32'h1c00_0010);
        tick();
        inst_req = 1'b0; slv_addr_ok = 1'b0; slv_data_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t4_drain_inst_ok", 32'(inst_data_ok), 32'd1);
            tick();
        end
        slv_data_ok = 1'b0;
        #1;
        chk("t4_idle", 32'(idle), 32'd1);

        // Response with nothing outstanding.
        slv_data_ok = 1'b1;
        #1;
        chk("t5_inst_ok", 32'(inst_data_ok), 32'd0);
        chk("t5_data_ok", 32'(data_data_ok), 32'd0);
        tick();
        slv_data_ok = 1'b0;
        #1;
        chk("t5_proto_err", 32'(proto_err), 32'd1);
        tick();
        tick();
        chk("t5_proto_err_held", 32'(proto_err), 32'd1);

        // Reset with three outstanding drops their tags.
        data_req = 1'b1; slv_addr_ok = 1'b1;
        tick();
        tick();
        tick();
        data_req = 1'b0; slv_addr_ok = 1'b0;
        #1;
        chk("t6_busy", 32'(idle), 32'd0);
        resetn = 1'b0; data_req = 1'b1; slv_addr_ok = 1'b1; slv_data_ok = 1'b1;
        #1;
        chk("t6_rst_slv_req", 32'(slv_req), 32'd0);
        chk("t6_rst_addr_ok", 32'(data_addr_ok), 32'd0);
        chk("t6_rst_data_ok", 32'(data_data_ok), 32'd0);
        tick();
        resetn = 1'b1; data_req = 1'b0; slv_addr_ok = 1'b0; slv_data_ok = 1'b0;
        #1;
        chk("t6_idle", 32'(idle), 32'd1);
        chk("t6_proto_err_clr", 32'(proto_err), 32'd0);
        slv_data_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t6_stale_data_ok", 32'(data_data_ok), 32'd0);
            chk("t6_stale_inst_ok", 32'(inst_data_ok), 32'd0);
            tick();
        end
        slv_data_ok = 1'b0;
        #1;
        chk("t6_proto_err", 32'(proto_err), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
